// File: rtl/adiabatic_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : adiabatic_alu_seq_if
// Brief   : Operand/result handshake bundle and phase-rail outputs for
//           adiabatic_alu_seq.
// Revision: 1.0 - initial release
// ============================================================================
interface adiabatic_alu_seq_if #(
    parameter int DATA_W = 16,
    parameter int PHASES = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              op_sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out;
    logic              cout;
    logic              overflow;
    logic              calculation_done;
    logic              busy;
    logic [PHASES-1:0] clkp_out;
    logic [PHASES-1:0] clkn_out;
    logic [31:0]       op_count;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, out, cout, overflow, calculation_done,
               busy, clkp_out, clkn_out, op_count
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, out, cout, overflow, calculation_done,
               busy, clkp_out, clkn_out, op_count
    );
endinterface
`default_nettype wire

// File: rtl/adiabatic_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : adiabatic_alu_seq
// Brief   : Add/sub ALU with built-in Bennett phase sequencer and valid/ready
//           handshakes. Define ADIABATIC_ALU_OPCOUNT_EN to build op_count.
// Revision: 1.0 - initial release
// ============================================================================
module adiabatic_alu_seq #(
    parameter int DATA_W      = 16,
    parameter int PHASES      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    adiabatic_alu_seq_if.slave  bus
);
    localparam int CNT_W  = $clog2(PHASES);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  c_LAST_PHASE = CNT_W'(PHASES - 1);
    localparam logic [HOLD_W-1:0] c_LAST_HOLD  =
        HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_SETTLE    = 3'd2,
        S_DONE      = 3'd3,
        S_RAMP_DOWN = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PHASES-1:0]   clkp_q, clkp_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                cin_q, cin_d, sub_q, sub_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                cout_q, cout_d, ovf_q, ovf_d;
    logic                valid_q, valid_d, done_q, done_d;

    logic [DATA_W-1:0]   w_beff;
    logic [DATA_W:0]     w_sum;
    logic                w_ovf;
    logic                w_enter_done;

    // Result is formed from the captured operands, never the live inputs.
    always_comb begin
        w_beff = sub_q ? ~b_q : b_q;
        w_sum  = {1'b0, a_q} + {1'b0, w_beff} + {{DATA_W{1'b0}}, cin_q};
        w_ovf  = (a_q[DATA_W-1] == w_beff[DATA_W-1]) &&
                 (w_sum[DATA_W-1] != a_q[DATA_W-1]);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        clkp_d       = clkp_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        sub_d        = sub_q;
        out_d        = out_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
        w_enter_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cin_d   = bus.cin;
                    sub_d   = bus.op_sub;
                    clkp_d  = PHASES'(1);
                    cnt_d   = CNT_W'(1);
                    state_d = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                clkp_d[cnt_q] = 1'b1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == c_LAST_PHASE) begin
                    hold_d = '0;
                    if (HOLD_CYCLES == 0) begin
                        w_enter_done = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == c_LAST_HOLD) begin
                    w_enter_done = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    valid_d              = 1'b0;
                    clkp_d[PHASES-1]     = 1'b0;
                    cnt_d                = c_LAST_PHASE - CNT_W'(1);
                    state_d              = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                clkp_d[cnt_q] = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_enter_done) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            done_d  = 1'b1;
            out_d   = w_sum[DATA_W-1:0];
            cout_d  = w_sum[DATA_W];
            ovf_d   = w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            clkp_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sub_q   <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            clkp_q  <= clkp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sub_q   <= sub_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef ADIABATIC_ALU_OPCOUNT_EN
    logic        w_out_hs;
    logic [31:0] op_count_q, op_count_d;

    // Saturating count of consumed results.
    always_comb begin
        w_out_hs   = (state_q == S_DONE) && bus.out_ready;
        op_count_d = op_count_q;
        if (w_out_hs && (op_count_q != 32'hFFFF_FFFF)) begin
            op_count_d = op_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign bus.op_count = op_count_q;
`else
    assign bus.op_count = '0;
`endif

    assign bus.in_ready         = (state_q == S_IDLE);
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.out_valid        = valid_q;
    assign bus.calculation_done = done_q;
    assign bus.out              = out_q;
    assign bus.cout             = cout_q;
    assign bus.overflow         = ovf_q;
    assign bus.clkp_out         = clkp_q;
    assign bus.clkn_out         = ~clkp_q;
endmodule
`default_nettype wire

// File: doc/adiabatic_alu_seq.md
Name: adiabatic_alu_seq

Overview:
- Parametrised successor to the fixed 16-bit, 8-phase adiabatic adder wrapper.
- Contains its own Bennett phase sequencer: ramps the phases up one at a time, settles, holds the result until it is consumed, then ramps down in reverse.
- Adds valid/ready handshakes on both sides, operand capture, add/sub mode and signed overflow.
- Sits between the ALU operand front end and the result writeback stage.

Parameters:
- DATA_W, 16: operand and result width (>=2).
- PHASES, 8: number of Bennett clock phase pairs (>=2).
- HOLD_CYCLES, 2: settle cycles after all phases are up, before the result is valid (0 allowed).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high when the block can accept operands (state IDLE).
- a  input  DATA_W  operand A.
- b  input  DATA_W  operand B.
- cin  input  1  carry in.
- op_sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out  output  DATA_W  result.
- cout  output  1  carry out.
- overflow  output  1  signed overflow.
- calculation_done  output  1  one-cycle pulse on the cycle out_valid first rises.
- busy  output  1  high when state is not IDLE.
- clkp_out  output  PHASES  positive phase rails.
- clkn_out  output  PHASES  negative phase rails; always the bitwise inverse of clkp_out.
- op_count  output  32  completed-operation counter (see Optional Feature).

Behaviour:
- Reset (clk edge with reset=1) takes priority over everything, including mid-operation:
  - state=IDLE, clkp_out=0, clkn_out=all ones.
  - out_valid=0, calculation_done=0, out=0, cout=0, overflow=0, op_count=0.
  - in_ready=1 and busy=0 from the next cycle.
- States: IDLE, RAMP_UP, SETTLE, DONE, RAMP_DOWN.
- IDLE:
  - in_ready=1.
  - Accept edge = in_valid & in_ready. On it: capture a, b, cin and op_sub; set clkp bit0; phase counter <= 1; go to RAMP_UP.
- RAMP_UP:
  - Each edge sets clkp bit [counter] and increments the counter. Bits are cumulative.
  - On the edge that sets bit PHASES-1, go to SETTLE, or straight to DONE if HOLD_CYCLES=0.
- SETTLE:
  - Counts HOLD_CYCLES edges, then goes to DONE.
- DONE:
  - out_valid=1; out, cout and overflow registered on entry. calculation_done pulses for the first DONE cycle.
  - Stays in DONE while out_ready=0. clkp stays all ones and outputs stay stable.
- Latency: out_valid is high after the (PHASES+HOLD_CYCLES)th rising edge, counting the accept edge as the first (10 with defaults).
- Output handshake edge (out_valid & out_ready): out_valid <= 0; clear clkp bit PHASES-1; go to RAMP_DOWN.
- RAMP_DOWN:
  - Each edge clears the next lower bit.
  - The edge that clears bit0 also enters IDLE, so in_ready rises PHASES edges after the handshake edge.
- out, cout and overflow keep their last value until the next result is registered.
- Operand inputs and in_valid are ignored outside IDLE. A held in_valid starts the next operation on the first IDLE edge.
- Arithmetic, using captured operands:
  - beff = op_sub ? ~b : b.
  - {cout, out} = a + beff + cin, computed DATA_W+1 wide.
  - Plain subtraction requires cin=1.
  - overflow = (a[MSB] == beff[MSB]) && (out[MSB] != a[MSB]).
- No simultaneous input and output handshakes are possible: in_ready=0 whenever out_valid=1.

Optional Feature:
- Macro ADIABATIC_ALU_OPCOUNT_EN.
- Defined: op_count increments on each output handshake edge, saturates at 0xFFFFFFFF, and is cleared by reset.
- Undefined: op_count is tied to 0 and no counter flops are built.
- The port is present in both builds.

Test Plan:
- Defaults; a=0x1234, b=0x4321, cin=0, add -> out=0x5555, cout=0, overflow=0.
  - clkp_out steps 0x01, 0x03, ... 0xFF on consecutive edges.
  - out_valid and calculation_done high after the 10th edge; calculation_done high for exactly 1 cycle.
- Carry/overflow:
  - 0xFFFF+0x0001, cin=0 -> out=0x0000, cout=1, overflow=0.
  - 0x7FFF+0x0001 -> out=0x8000, cout=0, overflow=1.
- Subtract: a=0x0005, b=0x0007, cin=1, op_sub=1 -> out=0xFFFE, cout=0, overflow=0.
  - 0x8000-0x0001 -> out=0x7FFF, overflow=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> clkp_out=0xFF and out_valid=1 throughout, with stable outputs.
  - Then out_ready=1 -> clkp_out 0x7F, 0x3F ... 0x00 over 8 edges; in_ready=1 with 0x00.
  - clkn_out equals ~clkp_out on every cycle.
- Reset mid-ramp: reset when clkp_out=0x07 -> next edge clkp_out=0x00, clkn_out=0xFF, out_valid=0, out=0, busy=0, in_ready=1.
- Back-to-back with in_valid held high and operands changed mid-op:
  - The first result uses the captured operands.
  - The second op is accepted on the first IDLE edge.
  - op_count=2 with ADIABATIC_ALU_OPCOUNT_EN defined, 0 without.
